// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the TMDS link controller:
//   - state_t   : link bring-up FSM state encoding (HOLD -> PRIME -> RUN)
//   - TOK_xx    : the four TMDS control-period tokens, indexed by {C1,C0}
//   - ctrl_token: maps a {C1,C0} pair to its 10-bit control token
// No ports (package).
// -----------------------------------------------------------------------------
package tmds_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] tok;
        case (c)
            2'b00:   tok = TOK_00;
            2'b01:   tok = TOK_01;
            2'b10:   tok = TOK_10;
            default: tok = TOK_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/display_timing.sv
// -----------------------------------------------------------------------------
// display_timing
// Raster position counters with sync, active-area and frame-start generation.
// All outputs are registered and describe the same raster position.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_en             : raster runs during the coming cycle (link in RUN)
//   i_start          : coming cycle is the first RUN cycle (restart at 0,0)
//   o_sx, o_sy       : current pixel / line position
//   o_de             : active-area strobe
//   o_hsync, o_vsync : sync levels (polarity set by SYNC_ACT)
//   o_frame          : one-cycle pulse at position (0,0)
// -----------------------------------------------------------------------------
module display_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_ACT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_start,
    output logic [15:0] o_sx,
    output logic [15:0] o_sy,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame
);

    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic SA      = (SYNC_ACT != 0);

    logic [15:0] r_sx, r_sy;
    logic        r_de, r_hs, r_vs, r_frame;
    logic [15:0] w_nx, w_ny;

    // Position the registers will hold after this edge.
    always_comb begin
        w_nx = r_sx + 16'd1;
        w_ny = r_sy;
        if (i_start) begin
            w_nx = '0;
            w_ny = '0;
        end else if (r_sx == 16'(H_TOTAL - 1)) begin
            w_nx = '0;
            w_ny = (r_sy == 16'(V_TOTAL - 1)) ? 16'd0 : r_sy + 16'd1;
        end
    end

    // Flags are decoded from the next position so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_sx    <= '0;
            r_sy    <= '0;
            r_de    <= 1'b0;
            r_hs    <= ~SA;
            r_vs    <= ~SA;
            r_frame <= 1'b0;
        end else begin
            r_sx    <= w_nx;
            r_sy    <= w_ny;
            r_de    <= (w_nx < 16'(H_ACTIVE)) && (w_ny < 16'(V_ACTIVE));
            r_hs    <= ((w_nx >= 16'(H_ACTIVE + H_FP)) &&
                        (w_nx <  16'(H_ACTIVE + H_FP + H_SYNC))) ? SA : ~SA;
            r_vs    <= ((w_ny >= 16'(V_ACTIVE + V_FP)) &&
                        (w_ny <  16'(V_ACTIVE + V_FP + V_SYNC))) ? SA : ~SA;
            r_frame <= (w_nx == 16'd0) && (w_ny == 16'd0);
        end
    end

    assign o_sx    = r_sx;
    assign o_sy    = r_sy;
    assign o_de    = r_de;
    assign o_hsync = r_hs;
    assign o_vsync = r_vs;
    assign o_frame = r_frame;

endmodule

// File: rtl/tmds_link_ctrl.sv
// -----------------------------------------------------------------------------
// tmds_link_ctrl
// Brings up a TMDS serializer link (reset hold, settle, run), generates the
// raster timing, and muxes encoded pixel words / control tokens onto the
// three serializer channels, aligned to the external encoder latency.
// Ports:
//   i_clk, i_rst           : pixel clock, synchronous active-high reset
//   i_tmds_ch0..2   [9:0]  : encoded words, valid ENC_LAT cycles after o_pix_req
//   o_tmds_ch0..2   [9:0]  : registered words to the 10:1 serializers
//   o_sx, o_sy      [15:0] : current raster position
//   o_pix_req              : active-area strobe (request to the encoder)
//   o_hsync, o_vsync       : sync levels
//   o_frame                : frame-start pulse
//   o_rst_oserdes          : serializer reset (active high)
//   o_link_up              : high while the link is running
// -----------------------------------------------------------------------------
module tmds_link_ctrl
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_ACT = 0,
    parameter int ENC_LAT  = 1,
    parameter int RST_HOLD = 16,
    parameter int PRIME    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [9:0]  i_tmds_ch0,
    input  logic [9:0]  i_tmds_ch1,
    input  logic [9:0]  i_tmds_ch2,
    output logic [9:0]  o_tmds_ch0,
    output logic [9:0]  o_tmds_ch1,
    output logic [9:0]  o_tmds_ch2,
    output logic [15:0] o_sx,
    output logic [15:0] o_sy,
    output logic        o_pix_req,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame,
    output logic        o_rst_oserdes,
    output logic        o_link_up
);

    localparam logic SA = (SYNC_ACT != 0);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_rst_oserdes;
    logic        r_link_up;

    logic        w_start;
    logic        w_run_next;
    logic        w_de, w_hs, w_vs;

    // Alignment shift register; index ENC_LAT-1 lines up with i_tmds_*.
    logic [ENC_LAT-1:0] r_de_p, r_hs_p, r_vs_p;
    logic [9:0]         r_ch0_p1, r_ch1_p1, r_ch2_p1;

    // The raster must show (0,0) in the same cycle link_up first rises, so
    // the timing block is told one edge ahead that RUN is about to begin.
    assign w_start    = !i_rst && (r_state == ST_PRIME) && (r_cnt == 16'(PRIME - 1));
    assign w_run_next = !i_rst && ((r_state == ST_RUN) || w_start);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_HOLD;
            r_cnt         <= '0;
            r_rst_oserdes <= 1'b1;
            r_link_up     <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == 16'(RST_HOLD - 1)) begin
                        r_state       <= ST_PRIME;
                        r_cnt         <= '0;
                        r_rst_oserdes <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_PRIME: begin
                    if (r_cnt == 16'(PRIME - 1)) begin
                        r_state   <= ST_RUN;
                        r_cnt     <= '0;
                        r_link_up <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state       <= ST_HOLD;
                    r_cnt         <= '0;
                    r_rst_oserdes <= 1'b1;
                    r_link_up     <= 1'b0;
                end
            endcase
        end
    end

    display_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_ACT (SYNC_ACT)
    ) u_timing (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_run_next),
        .i_start (w_start),
        .o_sx    (o_sx),
        .o_sy    (o_sy),
        .o_de    (w_de),
        .o_hsync (w_hs),
        .o_vsync (w_vs),
        .o_frame (o_frame)
    );

    // Stage p0: delay de/sync by the encoder latency. Held clear outside
    // RUN so a restart never replays de from a previous frame.
    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state != ST_RUN)) begin
            r_de_p <= '0;
            r_hs_p <= {ENC_LAT{~SA}};
            r_vs_p <= {ENC_LAT{~SA}};
        end else begin
            r_de_p[0] <= w_de;
            r_hs_p[0] <= w_hs;
            r_vs_p[0] <= w_vs;
            for (int i = 1; i < ENC_LAT; i++) begin
                r_de_p[i] <= r_de_p[i-1];
                r_hs_p[i] <= r_hs_p[i-1];
                r_vs_p[i] <= r_vs_p[i-1];
            end
        end
    end

    // Stage p1: channel mux; encoder words are only taken while delayed de=1.
    always_ff @(posedge i_clk) begin
        if (!w_run_next) begin
            r_ch0_p1 <= TOK_00;
            r_ch1_p1 <= TOK_00;
            r_ch2_p1 <= TOK_00;
        end else if (r_de_p[ENC_LAT-1]) begin
            r_ch0_p1 <= i_tmds_ch0;
            r_ch1_p1 <= i_tmds_ch1;
            r_ch2_p1 <= i_tmds_ch2;
        end else begin
            r_ch0_p1 <= ctrl_token({r_vs_p[ENC_LAT-1], r_hs_p[ENC_LAT-1]});
            r_ch1_p1 <= TOK_00;
            r_ch2_p1 <= TOK_00;
        end
    end

    assign o_tmds_ch0    = r_ch0_p1;
    assign o_tmds_ch1    = r_ch1_p1;
    assign o_tmds_ch2    = r_ch2_p1;
    assign o_pix_req     = w_de;
    assign o_hsync       = w_hs;
    assign o_vsync       = w_vs;
    assign o_rst_oserdes = r_rst_oserdes;
    assign o_link_up     = r_link_up;

endmodule
